// File: rtl/cpu_clk_ctrl_if.sv
// Bus between the CPU clock sequencer and its environment: divider count, mode controls,
// and the generated clock enable, FSM state and cycle count.
interface cpu_clk_ctrl_if;
  logic [31:0] clkdiv;
  logic [1:0]  speed_sel;
  logic        run_en;
  logic        step_btn;
  logic        halt_req;
  logic        clr_cnt;
  logic        cpu_ce;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  modport master (
    output clkdiv, speed_sel, run_en, step_btn, halt_req, clr_cnt,
    input  cpu_ce, state, cycle_cnt
  );

  modport slave (
    input  clkdiv, speed_sel, run_en, step_btn, halt_req, clr_cnt,
    output cpu_ce, state, cycle_cnt
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// CPU clock sequencer: issues a one-clk cpu_ce in free-run, halt or debounced single-step
// modes, and counts the pulses issued.
module cpu_clk_ctrl #(
  parameter int unsigned TAP_BASE   = 20,
  parameter int unsigned TAP_STRIDE = 2,
  parameter int unsigned DB_BIT     = 17,
  parameter int unsigned DB_SAMPLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  cpu_clk_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(DB_SAMPLES + 1);

  typedef enum logic [1:0] {
    StHalt    = 2'b00,
    StRun     = 2'b01,
    StStep    = 2'b10,
    StWaitRel = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic            ce_q, ce_d;
  logic [31:0]     cycle_q, cycle_d;
  logic [1:0]      speed_q;
  logic            tap_q, db_q;
  logic            btn_meta_q, btn_sync_q;
  logic            btn_stable_q, btn_stable_d;
  logic [CntW-1:0] db_cnt_q, db_cnt_d;

  logic [4:0] tap_idx;
  logic       tap, rate_chg, tick, db_strobe, btn_press;

  assign tap_idx   = 5'(TAP_BASE + TAP_STRIDE * 32'(bus.speed_sel));
  assign tap       = bus.clkdiv[tap_idx];
  // A rate change reloads the edge history from the new tap, so it cannot look like an edge.
  assign rate_chg  = (bus.speed_sel != speed_q);
  assign tick      = tap & ~tap_q & ~rate_chg;
  assign db_strobe = bus.clkdiv[DB_BIT] & ~db_q;

  always_comb begin
    db_cnt_d     = db_cnt_q;
    btn_stable_d = btn_stable_q;
    btn_press    = 1'b0;
    if (db_strobe) begin
      if (btn_sync_q != btn_stable_q) begin
        if (db_cnt_q == CntW'(DB_SAMPLES - 1)) begin
          btn_stable_d = ~btn_stable_q;
          db_cnt_d     = '0;
          btn_press    = ~btn_stable_q;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_d = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    unique case (state_q)
      StHalt: begin
        if (bus.run_en && !bus.halt_req) begin
          state_d = StRun;
        end else if (btn_press) begin
          state_d = StStep;
          ce_d    = 1'b1;
        end
      end
      StRun: begin
        if (!bus.run_en || bus.halt_req) begin
          state_d = StHalt;
        end else begin
          ce_d = tick;
        end
      end
      StStep:    state_d = StWaitRel;
      StWaitRel: if (!btn_stable_q) state_d = StHalt;
      default:   state_d = StHalt;
    endcase
  end

  always_comb begin
    cycle_d = cycle_q;
    if (bus.clr_cnt) begin
      cycle_d = '0;
    end else if (ce_q) begin
      cycle_d = cycle_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StHalt;
      ce_q         <= 1'b0;
      cycle_q      <= '0;
      speed_q      <= '0;
      tap_q        <= 1'b0;
      db_q         <= 1'b0;
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      btn_stable_q <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      ce_q         <= ce_d;
      cycle_q      <= cycle_d;
      speed_q      <= bus.speed_sel;
      tap_q        <= tap;
      db_q         <= bus.clkdiv[DB_BIT];
      btn_meta_q   <= bus.step_btn;
      btn_sync_q   <= btn_meta_q;
      btn_stable_q <= btn_stable_d;
      db_cnt_q     <= db_cnt_d;
    end
  end

  assign bus.cpu_ce    = ce_q;
  assign bus.state     = state_q;
  assign bus.cycle_cnt = cycle_q;

endmodule
